// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Imported by the arbiter top and its port mux.
package dmem_pkg;

  localparam int AW_DEF        = 14;
  localparam int DW_DEF        = 32;
  localparam int MEM_WORDS_DEF = 32;
  localparam int MAX_BURST_DEF = 4;
  localparam int STARVE_DEF    = 8;

  typedef enum logic {
    S_M0 = 1'b0,
    S_M1 = 1'b1
  } arb_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Steers the granted master onto the memory port, range-checks
// the access and returns read data only to the granted master.
module dmem_port_mux
  import dmem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic          en,
  input  logic          m0_gnt,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_gnt,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [DW-1:0] mem_rd,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          oob
);

  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  logic sel_we;
  logic gnt;
  logic in_range;

  always_comb begin
    mem_a  = m0_addr;
    mem_wd = m0_wdata;
    sel_we = 1'b0;
    gnt    = 1'b0;
    unique case (1'b1)
      m0_gnt: begin
        mem_a  = m0_addr;
        mem_wd = m0_wdata;
        sel_we = m0_we;
        gnt    = 1'b1;
      end
      m1_gnt: begin
        mem_a  = m1_addr;
        mem_wd = m1_wdata;
        sel_we = m1_we;
        gnt    = 1'b1;
      end
      default: begin
        sel_we = 1'b0;
        gnt    = 1'b0;
      end
    endcase
  end

  assign in_range = ({1'b0, mem_a} < LIMIT);

  // oob is ungated so the error flop never sees the reset net as data
  assign oob    = gnt & ~in_range;
  assign mem_we = en & sel_we & in_range;

  assign m0_rdata =
    (en & m0_gnt & in_range) ? mem_rd : '0;
  assign m1_rdata =
    (en & m1_gnt & in_range) ? mem_rd : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: MEM stage
// has priority, loader bursts are bounded and starvation-protected.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MEM_WORDS    = MEM_WORDS_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_last,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          err_oob
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [WW-1:0] W_LIMIT   = WW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_d;

  logic g0, g1;
  logic force_m1;
  logic oob;

  assign force_m1 = m1_req & (wait_q == W_LIMIT);

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_M0: begin
        if (m0_req & ~force_m1) begin
          g0 = 1'b1;
        end else if (m1_req) begin
          g1 = 1'b1;
          if (~m1_last && (MAX_BURST > 1)) begin
            state_d = S_M1;
            beat_d  = BEAT_ONE;
          end else begin
            beat_d  = '0;
          end
        end
      end
      S_M1: begin
        // the burst owns the port; M0 waits even when idle here
        if (m1_req) begin
          g1 = 1'b1;
          if (m1_last || (beat_q == BEAT_LAST)) begin
            state_d = S_M0;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BEAT_ONE;
          end
        end else begin
          state_d = S_M0;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = S_M0;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (g1 || !m1_req) begin
      wait_d = '0;
    end else if (wait_q != W_LIMIT) begin
      wait_d = wait_q + WW'(1);
    end
  end

  assign err_d = oob;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_M0;
      beat_q  <= '0;
      wait_q  <= '0;
      err_oob <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      err_oob <= err_d;
    end
  end

  assign m0_gnt   = rst & g0;
  assign m1_gnt   = rst & g1;
  assign m0_stall = m0_req & ~m0_gnt;

  dmem_port_mux #(
    .AW        (AW),
    .DW        (DW),
    .MEM_WORDS (MEM_WORDS)
  ) u_mux (
    .en       (rst),
    .m0_gnt   (g0),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m1_gnt   (g1),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .mem_rd   (mem_rd),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .m0_rdata (m0_rdata),
    .m1_rdata (m1_rdata),
    .oob      (oob)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and
// a queue of expected per-cycle results.
module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 32;

  typedef struct {
    string       tag;
    logic [4:0]  ctrl;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0;
  logic          m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt;
  logic          m0_stall;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0;
  logic          m1_we = 1'b0;
  logic          m1_last = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic          err_oob;

  logic [31:0] mem  [0:MW-1];
  logic [31:0] refm [0:MW-1];

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic prev_oob = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_stall (m0_stall),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_last  (m1_last),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rdata (m1_rdata),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .err_oob  (err_oob)
  );

  assign mem_rd = (mem_a < AW'(MW)) ?
    mem[mem_a[4:0]] : 32'hBAD0_0BAD;

  always @(posedge clk) begin
    if (mem_we && (mem_a < AW'(MW)))
      mem[mem_a[4:0]] <= mem_wd;
  end

  task automatic step(
    input string       tag,
    input logic        r,
    input logic        a_req,
    input logic        a_we,
    input logic [13:0] a_addr,
    input logic [31:0] a_wd,
    input logic        b_req,
    input logic        b_we,
    input logic        b_last,
    input logic [13:0] b_addr,
    input logic [31:0] b_wd,
    input logic        eg0,
    input logic        eg1
  );
    exp_t e;
    logic in0, in1;
    logic [4:0] obs;
    rst      = r;
    m0_req   = a_req;
    m0_we    = a_we;
    m0_addr  = a_addr;
    m0_wdata = a_wd;
    m1_req   = b_req;
    m1_we    = b_we;
    m1_last  = b_last;
    m1_addr  = b_addr;
    m1_wdata = b_wd;
    in0 = (a_addr < 14'd32);
    in1 = (b_addr < 14'd32);
    e.tag  = tag;
    e.ctrl = {eg0, eg1, a_req & ~eg0,
              (eg0 & a_we & in0) | (eg1 & b_we & in1),
              r & prev_oob};
    e.rd0 = (eg0 && in0) ? refm[a_addr[4:0]] : '0;
    e.rd1 = (eg1 && in1) ? refm[b_addr[4:0]] : '0;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    obs = {m0_gnt, m1_gnt, m0_stall, mem_we, err_oob};
    checks++;
    assert (obs === e.ctrl) else begin
      failures++;
      $error("FAIL %s ctrl{g0,g1,stall,we,err} got=%b exp=%b",
             e.tag, obs, e.ctrl);
    end
    checks++;
    assert (m0_rdata === e.rd0) else begin
      failures++;
      $error("FAIL %s m0_rdata got=%h exp=%h",
             e.tag, m0_rdata, e.rd0);
    end
    checks++;
    assert (m1_rdata === e.rd1) else begin
      failures++;
      $error("FAIL %s m1_rdata got=%h exp=%h",
             e.tag, m1_rdata, e.rd1);
    end
    @(posedge clk);
    if (r) begin
      if (eg0 && a_we && in0) refm[a_addr[4:0]] = a_wd;
      if (eg1 && b_we && in1) refm[b_addr[4:0]] = b_wd;
    end
    prev_oob = r & ((eg0 & ~in0) | (eg1 & ~in1));
    #1;
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      mem[i]  = 32'(i + 2);
      refm[i] = 32'(i + 2);
    end
    @(posedge clk);
    #1;
    // reset state: no grants, stall follows request
    step("rst", 0, 1,0,14'd3,0, 1,0,0,14'd3,0, 0,0);
    step("m0_wr5", 1, 1,1,14'd5,32'hDEAD_BEEF, 0,0,0,0,0, 1,0);
    step("m0_rd5", 1, 1,0,14'd5,0, 0,0,0,0,0, 1,0);
    step("oob_wr40", 1, 1,1,14'd40,32'd1, 0,0,0,0,0, 1,0);
    step("rd8_err", 1, 1,0,14'd8,0, 0,0,0,0,0, 1,0);
    step("err_clr", 1, 0,0,14'd8,0, 0,0,0,0,0, 0,0);

    // contention from reset
    step("rst2", 0, 1,0,14'd9,0, 1,1,0,14'd16,0, 0,0);
    for (int i = 0; i < 8; i++)
      step("cont_m0", 1, 1,0,14'(i),0,
           1,1,0,14'd16,32'hA000_0000, 1,0);
    step("force_b0", 1, 1,0,14'd9,0,
         1,1,0,14'd16,32'hA000_0000, 0,1);
    step("force_b1", 1, 1,0,14'd9,0,
         1,1,0,14'd17,32'hA000_0001, 0,1);
    step("force_b2", 1, 1,0,14'd9,0,
         1,1,1,14'd18,32'hA000_0002, 0,1);
    step("cont_back", 1, 1,0,14'd16,0, 0,0,0,0,0, 1,0);

    // preemption after MAX_BURST beats
    step("pre_b0", 1, 0,0,14'd8,0, 1,1,0,14'd0,32'h100, 0,1);
    step("pre_b1", 1, 1,0,14'd8,0, 1,1,0,14'd1,32'h101, 0,1);
    step("pre_b2", 1, 1,0,14'd8,0, 1,1,0,14'd2,32'h102, 0,1);
    step("pre_b3", 1, 1,0,14'd8,0, 1,1,0,14'd3,32'h103, 0,1);
    step("pre_m0", 1, 1,0,14'd8,0, 1,1,0,14'd4,32'h104, 1,0);
    step("pre_b4", 1, 0,0,14'd8,0, 1,1,0,14'd4,32'h104, 0,1);
    step("pre_b5", 1, 0,0,14'd8,0, 1,1,1,14'd5,32'h105, 0,1);
    for (int i = 0; i < 6; i++)
      step("pre_rd", 1, 1,0,14'(i),0, 0,0,0,0,0, 1,0);

    // early last on beat 2
    step("el_b0", 1, 0,0,14'd20,0, 1,1,0,14'd20,32'h200, 0,1);
    step("el_b1", 1, 1,0,14'd20,0, 1,1,1,14'd21,32'h201, 0,1);
    step("el_m0", 1, 1,0,14'd21,0, 0,0,0,0,0, 1,0);

    // reset in the middle of a burst
    step("rb_b0", 1, 0,0,14'd22,0, 1,1,0,14'd22,32'h300, 0,1);
    step("rb_rst", 0, 1,0,14'd22,0, 1,1,0,14'd23,32'h301, 0,0);
    step("rb_m0", 1, 1,0,14'd23,0, 1,1,0,14'd23,32'h301, 1,0);
    step("rb_rd22", 1, 1,0,14'd22,0, 0,0,0,0,0, 1,0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (14-bit word address, 32-bit data, async read, sync write on posedge clk) between two requesters.
- M0 is the pipeline MEM stage and has priority. M1 is the loader/debug port, which issues bursts.
- Produces a stall for the MEM stage when M1 owns the port. Guarantees M1 forward progress via a starvation limit.
- Sits between the pipeline MEM stage and the data memory instance.

Parameters:
- AW, 14, word-address width.
- DW, 32, data width.
- MEM_WORDS, 32, implemented memory depth in words; addresses >= MEM_WORDS are out of range.
- MAX_BURST, 4, maximum M1 beats per ownership before forced release (>=1).
- STARVE_LIMIT, 8, cycles M1 may wait before being forced a grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  MEM-stage access request.
- m0_we  in  1  MEM-stage write enable.
- m0_addr  in  AW  MEM-stage word address.
- m0_wdata  in  DW  MEM-stage write data.
- m0_gnt  out  1  M0 owns the port this cycle.
- m0_stall  out  1  m0_req & ~m0_gnt; holds the pipeline.
- m0_rdata  out  DW  read data, valid when m0_gnt.
- m1_req  in  1  loader request.
- m1_we  in  1  loader write enable.
- m1_last  in  1  final beat of the current burst.
- m1_addr  in  AW  loader word address.
- m1_wdata  in  DW  loader write data.
- m1_gnt  out  1  M1 owns the port this cycle.
- m1_rdata  out  DW  read data, valid when m1_gnt.
- mem_a  out  AW  to memory address.
- mem_wd  out  DW  to memory write data.
- mem_we  out  1  to memory write enable.
- mem_rd  in  DW  from memory async read data.
- err_oob  out  1  registered one-cycle pulse: the previous cycle's granted access was out of range.

Behaviour:
- State register, two states: S_M0 (default, M0 priority) and S_M1 (M1 burst owns the port).
- Registers: state, beat_cnt (clog2(MAX_BURST) bits), wait_cnt (saturates at STARVE_LIMIT), err_oob.
- Reset (rst=0, asynchronous): state=S_M0, beat_cnt=0, wait_cnt=0, err_oob=0.
- While rst=0, outputs are forced: m0_gnt=0, m1_gnt=0, mem_we=0, m0_stall=m0_req.
- Grants are combinational from state and requests, zero latency, matching the async memory read. Read data is returned in the same cycle as the grant.
- force = m1_req & (wait_cnt == STARVE_LIMIT).
- S_M0 rules:
  - m0_req & ~force -> m0_gnt.
  - Otherwise m1_req -> m1_gnt. Go to S_M1 unless m1_last is high or MAX_BURST==1; beat_cnt <= 1.
  - Simultaneous requests with wait_cnt < STARVE_LIMIT: M0 wins.
- S_M1 rules:
  - m1_req -> m1_gnt; M0 is stalled regardless of m0_req.
  - Return to S_M0 when: the granted beat has m1_last=1; or beat_cnt == MAX_BURST-1 on a granted beat (preemption); or m1_req=0 (no grant that cycle).
  - beat_cnt increments per granted beat and clears on exit.
- wait_cnt:
  - Increments when m1_req & ~m1_gnt, saturating at STARVE_LIMIT.
  - Clears on m1_gnt or when m1_req=0.
- Port mux:
  - mem_a/mem_wd come from the granted master.
  - With no grant: mem_a=m0_addr, mem_wd=m0_wdata, mem_we=0.
  - mem_we = granted master's we & in_range, where in_range = addr < MEM_WORDS.
- Out-of-range granted access:
  - Write is suppressed; granted master's rdata=0.
  - err_oob=1 on the following cycle, one cycle only unless the next access is also out of range.
- Non-granted master's rdata: 0.
- A write takes effect at the clk edge ending the grant cycle. A read in the next cycle to the same address returns the new value.
- Reset mid-burst: state returns to S_M0; no write occurs in the reset cycle. The loader must reissue the burst.

Decomposition:
- Shared package dmem_pkg: state encoding (S_M0=1'b0, S_M1=1'b1), AW/DW defaults, MEM_WORDS.
- One natural sub-module, dmem_port_mux: combinational selection of address/data/we, range check, and rdata steering.
- The FSM and counters stay in dmem_arbiter.

Test Plan:
- Write then read on M0: m0 write addr 5 data 32'hDEAD_BEEF, next cycle m0 read addr 5 -> m0_gnt=1 both cycles, m0_rdata=32'hDEADBEEF, m0_stall=0.
- Contention: m0_req and m1_req both high from reset, wait below limit -> m0_gnt for 8 cycles. Cycle 9: force, m1_gnt=1, m0_stall=1. Next cycle M1 continues the burst; M0 stays stalled.
- Burst preemption, MAX_BURST=4: M1 writes addr 0..5 with m1_last only on the 6th beat -> 4 grants, back to S_M0, M0 served if requesting, remaining 2 beats granted afterwards.
- Early last: M1 2-beat burst with m1_last on beat 2 -> exit to S_M0 after 2 grants; m0_gnt resumes the next cycle.
- Out of range: m0 write addr 40, data 1 -> mem_we=0, m0_rdata=0, err_oob=1 the next cycle only. A subsequent read of addr 8 returns 32'h0000000A, unchanged.
- Reset mid-burst: rst low during M1 beat 2 -> grants=0 and mem_we=0 immediately. After release, state is S_M0, counters are 0, and an M0 request is granted on the first cycle.
